// File: rtl/m_fetch_queue_if.sv
// Fetch queue boundary: instruction-memory request/response, decoder output and redirect.
interface m_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        out_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_err, out_ready,
    output mem_req_valid, mem_req_addr,
    output out_valid, out_instruction, out_pc, out_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_err, out_ready,
    input  mem_req_valid, mem_req_addr,
    input  out_valid, out_instruction, out_pc, out_fault
  );
endinterface

// File: rtl/m_fetch_queue.sv
// Instruction fetch/prefetch buffer: sequential word fetches, in-order buffering,
// redirect flush with stale-response dropping, and fault halting.
module m_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  m_fetch_queue_if.master fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_START, S_FETCH, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count, outstanding, drop;
  logic [PW-1:0] q_head, q_tail, pc_rd, pc_wr;

  logic [31:0]   q_data  [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic          q_err   [DEPTH];
  logic [31:0]   pc_fifo [DEPTH];

  logic          redirect, req_fire, rsp_fire, rsp_keep, push, pop;
  logic [CW:0]   credit_used;

  // A redirect during the start cycle has no effect at all.
  assign redirect    = fq.redirect_valid && (state != S_START);
  assign credit_used = {1'b0, count} + {1'b0, outstanding};

  assign fq.mem_req_valid = (state == S_FETCH) && (credit_used < DEPTH_W) && !fq.redirect_valid;
  assign fq.mem_req_addr  = fetch_pc;

  assign req_fire = fq.mem_req_valid && fq.mem_req_ready;
  assign rsp_fire = fq.mem_rsp_valid;
  assign rsp_keep = rsp_fire && (drop == '0);
  assign push     = rsp_keep && !redirect;
  assign pop      = fq.out_valid && fq.out_ready;

  assign fq.out_valid       = (count != '0);
  assign fq.out_fault       = fq.out_valid && q_err[q_head];
  assign fq.out_pc          = fq.out_valid ? q_pc[q_head] : '0;
  assign fq.out_instruction = (fq.out_valid && !q_err[q_head]) ? q_data[q_head] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_START;
    else        state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: begin
        if (redirect)                      state_nxt = S_FETCH;
        else if (push && fq.mem_rsp_err)   state_nxt = S_HALT;
      end
      S_HALT:  if (redirect) state_nxt = S_FETCH;
      default: state_nxt = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      pc_rd       <= '0;
      pc_wr       <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (redirect) begin
        // Everything still in flight after this edge is stale, including nothing issued now.
        fetch_pc <= fq.redirect_pc & 32'hFFFF_FFFC;
        drop     <= outstanding - CW'(rsp_fire);
        count    <= '0;
        q_head   <= '0;
        q_tail   <= '0;
        pc_rd    <= '0;
        pc_wr    <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
          pc_wr    <= pc_wr + PW'(1);
        end
        if (rsp_fire && (drop != '0)) drop <= drop - CW'(1);
        if (rsp_keep) pc_rd  <= pc_rd + PW'(1);
        if (push)     q_tail <= q_tail + PW'(1);
        if (pop)      q_head <= q_head + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (req_fire) pc_fifo[pc_wr] <= fetch_pc;
    if (push) begin
      q_data[q_tail] <= fq.mem_rsp_data;
      q_pc[q_tail]   <= pc_fifo[pc_rd];
      q_err[q_tail]  <= fq.mem_rsp_err;
    end
  end

  // Credit accounting must never oversubscribe the queue, and memory must never answer unasked.
  a_credit: assert property (@(posedge clk) disable iff (!rst_n) credit_used <= DEPTH_W);
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(fq.mem_rsp_valid && (outstanding == '0)));
endmodule

// File: tb/tb_m_fetch_queue.sv
// Self-checking bench for m_fetch_queue: randomized memory/decoder timing against a
// transaction-level model (expected output stream = memory image at sequential PCs).
module tb_m_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    int unsigned epoch;
    int unsigned avail;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;

  m_fetch_queue_if fi();

  m_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fi)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] mq[$];
  req_t        inflight[$];
  logic [31:0] fetch_pc_m;
  int unsigned epoch;
  int unsigned cyc;
  bit          halted;
  bit          started;

  // Stimulus knobs (percent, redirect per mille).
  int          p_ready, p_rsp, p_out, p_redir;
  bit          force_redir;
  logic [31:0] redir_target;
  bit          fault_en, rand_faults;
  logic [31:0] fault_addr;

  // Observed traffic logs.
  int          req_cnt;
  logic [31:0] req_log[$];
  out_t        out_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit err_fn(input logic [31:0] a);
    return (fault_en && (a == fault_addr)) || (rand_faults && (a[6:2] == 5'h13));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    req_cnt = 0;
    req_log.delete();
    out_log.delete();
  endtask

  task automatic set_knobs(input int rdy, input int rsp, input int outr, input int redir);
    p_ready = rdy;
    p_rsp   = rsp;
    p_out   = outr;
    p_redir = redir;
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    fi.redirect_valid = 1'b0;
    fi.redirect_pc    = '0;
    fi.mem_req_ready  = 1'b0;
    fi.mem_rsp_valid  = 1'b0;
    fi.mem_rsp_data   = '0;
    fi.mem_rsp_err    = 1'b0;
    fi.out_ready      = 1'b0;
    #1;
    check("rst_out_valid", fi.out_valid, 1'b0);
    check("rst_out_fault", fi.out_fault, 1'b0);
    check("rst_out_instr", fi.out_instruction, 32'h0);
    check("rst_out_pc", fi.out_pc, 32'h0);
    check("rst_req_valid", fi.mem_req_valid, 1'b0);
    mq.delete();
    inflight.delete();
    fetch_pc_m = RESET_PC;
    halted     = 1'b0;
    started    = 1'b0;
    clear_logs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle();
    bit   rsp_now, redir_now, redir_eff, exp_req;
    req_t e;

    redir_now = force_redir || (started && ($urandom_range(999) < p_redir));
    fi.redirect_valid = redir_now;
    fi.redirect_pc    = force_redir ? redir_target : $urandom();
    fi.mem_req_ready  = ($urandom_range(99) < p_ready);
    fi.out_ready      = ($urandom_range(99) < p_out);
    rsp_now = (inflight.size() != 0) && (cyc >= inflight[0].avail) && ($urandom_range(99) < p_rsp);
    fi.mem_rsp_valid = rsp_now;
    if (rsp_now) begin
      fi.mem_rsp_data = mem_word(inflight[0].pc);
      fi.mem_rsp_err  = err_fn(inflight[0].pc);
    end else begin
      fi.mem_rsp_data = $urandom();
      fi.mem_rsp_err  = 1'($urandom_range(1));
    end
    #1;

    exp_req = started && !halted && ((mq.size() + inflight.size()) < DEPTH) && !redir_now;
    check("req_valid", fi.mem_req_valid, exp_req);
    if (exp_req) check("req_addr", fi.mem_req_addr, fetch_pc_m);
    check("out_valid", fi.out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("out_pc", fi.out_pc, mq[0]);
      check("out_fault", fi.out_fault, err_fn(mq[0]));
      check("out_instr", fi.out_instruction, err_fn(mq[0]) ? 32'h0 : mem_word(mq[0]));
    end

    if (fi.mem_req_valid && fi.mem_req_ready) begin
      req_cnt++;
      req_log.push_back(fi.mem_req_addr);
    end
    if (fi.out_valid && fi.out_ready)
      out_log.push_back('{pc: fi.out_pc, instr: fi.out_instruction, fault: fi.out_fault});

    @(posedge clk);
    cyc++;
    redir_eff = redir_now && started;
    if ((mq.size() != 0) && fi.out_ready) void'(mq.pop_front());
    if (rsp_now) begin
      e = inflight.pop_front();
      if ((e.epoch == epoch) && !redir_eff) begin
        mq.push_back(e.pc);
        if (err_fn(e.pc)) halted = 1'b1;
      end
    end
    if (exp_req && fi.mem_req_ready) begin
      inflight.push_back('{pc: fetch_pc_m, epoch: epoch, avail: cyc});
      fetch_pc_m = fetch_pc_m + 32'd4;
    end
    if (redir_eff) begin
      mq.delete();
      epoch++;
      fetch_pc_m = fi.redirect_pc & 32'hFFFF_FFFC;
      halted     = 1'b0;
    end
    started = 1'b1;
    force_redir = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; epoch = 0;
    force_redir = 1'b0; redir_target = '0;
    fault_en = 1'b0; rand_faults = 1'b0; fault_addr = '0;
    set_knobs(100, 100, 100, 0);
    rst_n = 1'b1;
    #2;

    // Straight-line fetch, everything always ready, 1-cycle memory.
    do_reset();
    repeat (16) cycle();
    check("t1_req0", req_log[0], 32'h0);
    check("t1_req1", req_log[1], 32'h4);
    check("t1_req2", req_log[2], 32'h8);
    check("t1_req3", req_log[3], 32'hC);
    check("t1_out_count", out_log.size() >= 4, 1'b1);
    if (out_log.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        check("t1_out_pc", out_log[i].pc, 32'(4 * i));
        check("t1_out_instr", out_log[i].instr, mem_word(32'(4 * i)));
      end

    // Decoder stalled: credits stop requests at DEPTH, one pop frees one request.
    do_reset();
    set_knobs(100, 100, 0, 0);
    repeat (12) cycle();
    check("t2_req_cnt_full", req_cnt, 4);
    check("t2_req_valid_full", fi.mem_req_valid, 1'b0);
    p_out = 100;
    cycle();
    p_out = 0;
    repeat (8) cycle();
    check("t2_req_cnt_after_pop", req_cnt, 5);
    check("t2_extra_addr", req_log[4], 32'h10);

    // Redirect with three responses in flight; all three must be dropped.
    do_reset();
    set_knobs(100, 0, 100, 0);
    for (int g = 0; g < 20 && req_cnt < 3; g++) cycle();
    check("t3_setup_reqs", req_cnt, 3);
    force_redir = 1'b1;
    redir_target = 32'h0000_0103;
    cycle();
    p_rsp = 100;
    repeat (15) cycle();
    check("t3_first_new_req", req_log[3], 32'h100);
    check("t3_out_count", out_log.size() >= 2, 1'b1);
    check("t3_first_out_pc", out_log[0].pc, 32'h100);
    check("t3_second_out_pc", out_log[1].pc, 32'h104);

    // Fault at 0x8 halts fetching until a redirect.
    fault_en = 1'b1;
    fault_addr = 32'h8;
    do_reset();
    set_knobs(100, 100, 100, 0);
    repeat (14) cycle();
    check("t4_req_cnt_halt", req_cnt, 4);
    check("t4_req_valid_halt", fi.mem_req_valid, 1'b0);
    check("t4_fault_pc", out_log[2].pc, 32'h8);
    check("t4_fault_flag", out_log[2].fault, 1'b1);
    check("t4_fault_instr", out_log[2].instr, 32'h0);
    fault_en = 1'b0;
    force_redir = 1'b1;
    redir_target = 32'h40;
    cycle();
    repeat (6) cycle();
    check("t4_resume_addr", req_log[4], 32'h40);

    // Address wrap at the top of the 32-bit space.
    clear_logs();
    force_redir = 1'b1;
    redir_target = 32'hFFFF_FFF8;
    cycle();
    repeat (10) cycle();
    check("t5_wrap0", req_log[0], 32'hFFFF_FFF8);
    check("t5_wrap1", req_log[1], 32'hFFFF_FFFC);
    check("t5_wrap2", req_log[2], 32'h0000_0000);

    // Reset asserted with requests outstanding; fetch restarts at RESET_PC.
    set_knobs(100, 30, 50, 0);
    repeat (8) cycle();
    do_reset();
    set_knobs(100, 100, 100, 0);
    repeat (8) cycle();
    check("t6_restart_addr", req_log[0], RESET_PC);

    // Random soak: memory/decoder timing, redirects and faults all randomized.
    rand_faults = 1'b1;
    set_knobs(70, 60, 60, 20);
    repeat (4000) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
